// File: rtl/tdm_demux6.sv
// ---------------------------------------------------------------------------
// tdm_demux6
//   Receive-side TDM demultiplexer. A 1-bit serial stream carries one bit per
//   slot, with NUM_CH slots per frame. A slot counter tracks the position in
//   the frame and is aligned by frame_sync. Bits are collected in a shadow
//   register. All channel outputs update together once a frame is complete.
//
// Build option:
//   SYNC_CHECK_EN - adds the sync_err output and strict framing. A RUN slot-0
//                   sample without frame_sync is discarded and the FSM
//                   returns to IDLE. Undefined: free-running framing.
//
// Ports:
//   clk         system clock, rising edge
//   reset       synchronous active-high reset
//   din         serial TDM data bit
//   din_valid   din carries a valid slot sample this cycle
//   frame_sync  marks the current valid sample as slot 0
//   slot        slot index expected for the next valid sample
//   dout        last complete frame, dout[i] = bit of slot i
//   dout_valid  sticky, high once the first frame has been delivered
//   frame_done  one-cycle pulse when dout updates
//   sync_err    (SYNC_CHECK_EN only) one-cycle framing error pulse
// ---------------------------------------------------------------------------
module tdm_demux6 #(
    parameter int NUM_CH = 6,
    parameter int SEL_W  = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              din,
    input  logic              din_valid,
    input  logic              frame_sync,
    output logic [SEL_W-1:0]  slot,
    output logic [NUM_CH-1:0] dout,
    output logic              dout_valid,
    output logic              frame_done
`ifdef SYNC_CHECK_EN
    ,
    output logic              sync_err
`endif
);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    localparam logic [SEL_W-1:0] LAST_SLOT = SEL_W'(NUM_CH - 1);

    state_t             state_q, state_d;
    logic [SEL_W-1:0]   slot_d;
    logic [NUM_CH-1:0]  shadow_q, shadow_d;
    logic [NUM_CH-1:0]  dout_d;
    logic               dout_valid_d;
    logic               frame_done_d;
`ifdef SYNC_CHECK_EN
    logic               sync_err_d;
`endif

    // Next-state and output logic.
    // NOTE: every signal gets a default first, so no path leaves one unassigned
    // and no latch is inferred.
    always_comb begin
        state_d      = state_q;
        slot_d       = slot;
        shadow_d     = shadow_q;
        dout_d       = dout;
        dout_valid_d = dout_valid;
        frame_done_d = 1'b0;
`ifdef SYNC_CHECK_EN
        sync_err_d   = 1'b0;
`endif

        if (int'(slot) >= NUM_CH) begin
            // The counter never reaches these codes in normal operation.
            // Recover by re-hunting for frame_sync.
            state_d = IDLE;
            slot_d  = '0;
        end else if (din_valid) begin
            unique case (state_q)
                IDLE: begin
                    if (frame_sync) begin
                        shadow_d[0] = din;
                        slot_d      = SEL_W'(1);
                        state_d     = RUN;
                    end
                end
                RUN: begin
                    if (frame_sync && slot != '0) begin
                        // Early sync: drop the partial frame and restart at slot 0.
                        shadow_d[0] = din;
                        slot_d      = SEL_W'(1);
`ifdef SYNC_CHECK_EN
                        sync_err_d  = 1'b1;
`endif
                    end
`ifdef SYNC_CHECK_EN
                    else if (!frame_sync && slot == '0) begin
                        // Strict framing: each frame must start with sync.
                        sync_err_d = 1'b1;
                        slot_d     = '0;
                        state_d    = IDLE;
                    end
`endif
                    else begin
                        for (int i = 0; i < NUM_CH; i++) begin
                            if (slot == SEL_W'(i)) begin
                                shadow_d[i] = din;
                            end
                        end
                        if (slot == LAST_SLOT) begin
                            // Build dout from the live last bit, because shadow_q
                            // does not yet hold it on this edge.
                            dout_d       = {din, shadow_q[NUM_CH-2:0]};
                            frame_done_d = 1'b1;
                            dout_valid_d = 1'b1;
                            slot_d       = '0;
                        end else begin
                            slot_d = slot + SEL_W'(1);
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                    slot_d  = '0;
                end
            endcase
        end
    end

    // State registers.
    // NOTE: sequential state uses non-blocking assignments, so every register
    // samples the pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: shadow is a small register, not a memory. It is reset so
            // that no stale bits can leak into a later frame.
            state_q    <= IDLE;
            slot       <= '0;
            shadow_q   <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
            frame_done <= 1'b0;
`ifdef SYNC_CHECK_EN
            sync_err   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            slot       <= slot_d;
            shadow_q   <= shadow_d;
            dout       <= dout_d;
            dout_valid <= dout_valid_d;
            frame_done <= frame_done_d;
`ifdef SYNC_CHECK_EN
            sync_err   <= sync_err_d;
`endif
        end
    end

endmodule
